// File: rtl/scroll_window_ctrl.sv
// scroll_window_ctrl: scrolling DIGITS-nibble window over a message held in an internal nibble buffer.
// Latency: a full window load takes DIGITS+1 cycles; each scroll advance takes 2 cycles after the advance cycle.
// Backpressure: none; writes are accepted every cycle, and step/reload/run are ignored while busy (LOAD/FETCH).
module scroll_window_ctrl #(
  parameter int DIGITS   = 8,
  parameter int DEPTH    = 64,
  parameter int TICK_DIV = 100000000,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [3:0]          wr_data,
  input  logic [AW:0]         msg_len,
  input  logic                run,
  input  logic                dir,
  input  logic                step,
  input  logic                reload,
  output logic [4*DIGITS-1:0] disp_val,
  output logic [AW-1:0]       pos,
  output logic                busy,
  output logic                wrap
);

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
  localparam logic [CW-1:0] LD_LAST  = CW'(DIGITS);
  localparam logic [AW:0]   LEN_MAX  = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHOW  = 2'd2,
    FETCH = 2'd3
  } state_t;

  state_t state;
  state_t next_state;

  // Message buffer and its registered read port
  logic [3:0]    mem [DEPTH];
  logic [3:0]    rd_data;
  logic [AW-1:0] rd_addr;

  // Latched message length and the index just past the window's last digit.
  // rd_idx always equals (pos + DIGITS) mod len once a window is built, so a
  // left scroll reads it directly and no modulo hardware is needed.
  logic [AW:0]   len;
  logic [AW-1:0] len_last;
  logic [AW-1:0] rd_idx;

  logic [CW-1:0] ld_cnt;
  logic [DW-1:0] div_cnt;
  logic          fetch_ph;
  logic          fetch_dir;

  logic [AW:0]   len_clamp;
  logic [AW-1:0] load_start;
  logic [AW-1:0] rd_idx_inc;
  logic [AW-1:0] rd_idx_dec;
  logic [AW-1:0] pos_inc;
  logic [AW-1:0] pos_dec;
  logic          advance;

  logic          load_enter;
  logic          load_shift;
  logic          load_read;
  logic          fetch_shift;
  logic          fetch_enter;

  logic [4*DIGITS-1:0] disp_shl;
  logic [4*DIGITS-1:0] disp_shr;

  function automatic logic [AW-1:0] idx_inc(input logic [AW-1:0] idx, input logic [AW-1:0] last);
    return (idx == last) ? '0 : idx + AW'(1);
  endfunction

  function automatic logic [AW-1:0] idx_dec(input logic [AW-1:0] idx, input logic [AW-1:0] last);
    return (idx == '0) ? last : idx - AW'(1);
  endfunction

  // Shift helpers: new nibble enters at the LSB (left scroll/load) or at the MSB (right scroll)
  generate
    if (DIGITS == 1) begin : g_one_digit
      assign disp_shl = rd_data;
      assign disp_shr = rd_data;
    end else begin : g_multi_digit
      assign disp_shl = {disp_val[4*DIGITS-5:0], rd_data};
      assign disp_shr = {rd_data, disp_val[4*DIGITS-1:4]};
    end
  endgenerate

  // Length clamping, wrap-around index arithmetic and the advance condition
  always_comb begin
    len_clamp = msg_len;
    if (msg_len == '0) begin
      len_clamp = (AW+1)'(1);
    end else if (msg_len > LEN_MAX) begin
      len_clamp = LEN_MAX;
    end
    // A shorter new message may leave pos out of range; restart at its head then.
    load_start = ({1'b0, pos} >= len_clamp) ? '0 : pos;
    len_last   = AW'(len - (AW+1)'(1));
    rd_idx_inc = idx_inc(rd_idx, len_last);
    rd_idx_dec = idx_dec(rd_idx, len_last);
    pos_inc    = idx_inc(pos, len_last);
    pos_dec    = idx_dec(pos, len_last);
    advance    = (div_cnt == DIV_LAST) || step;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; run=0 wins over reload, which wins over an advance
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (run) begin
          next_state = LOAD;
        end
      end
      LOAD: begin
        if (ld_cnt == LD_LAST) begin
          next_state = SHOW;
        end
      end
      SHOW: begin
        if (!run) begin
          next_state = IDLE;
        end else if (reload) begin
          next_state = LOAD;
        end else if (advance) begin
          next_state = FETCH;
        end
      end
      FETCH: begin
        if (fetch_ph) begin
          next_state = SHOW;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Output/control decode: buffer read address and datapath strobes
  always_comb begin
    rd_addr     = rd_idx;
    load_enter  = (next_state == LOAD) && (state != LOAD);
    load_read   = (state == LOAD) && (ld_cnt != LD_LAST);
    load_shift  = (state == LOAD) && (ld_cnt != '0);
    fetch_enter = (state == SHOW) && (next_state == FETCH);
    fetch_shift = (state == FETCH) && fetch_ph;
    if ((state == FETCH) && !fetch_ph && fetch_dir) begin
      rd_addr = pos_dec;
    end
  end

  // Buffer write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read; a same-cycle write to the same address returns the old nibble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

  // Scroll time base: counts only while staying in SHOW, cleared otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if ((state == SHOW) && (next_state == SHOW)) begin
      div_cnt <= div_cnt + DW'(1);
    end else begin
      div_cnt <= '0;
    end
  end

  // Window datapath: length latch, load sequencing, fetch shifting, pos and wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len       <= (AW+1)'(1);
      pos       <= '0;
      rd_idx    <= '0;
      ld_cnt    <= '0;
      fetch_ph  <= 1'b0;
      fetch_dir <= 1'b0;
      disp_val  <= '0;
      busy      <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      wrap <= 1'b0;
      busy <= (next_state == LOAD) || (next_state == FETCH);

      if (load_enter) begin
        len    <= len_clamp;
        pos    <= load_start;
        rd_idx <= load_start;
        ld_cnt <= '0;
      end else if (state == LOAD) begin
        ld_cnt <= ld_cnt + CW'(1);
        if (load_read) begin
          rd_idx <= rd_idx_inc;
        end
      end

      if (load_shift) begin
        disp_val <= disp_shl;
      end

      if (fetch_enter) begin
        fetch_dir <= dir;
        fetch_ph  <= 1'b0;
      end else if (state == FETCH) begin
        fetch_ph <= ~fetch_ph;
      end

      if (fetch_shift) begin
        if (fetch_dir) begin
          disp_val <= disp_shr;
          pos      <= pos_dec;
          rd_idx   <= rd_idx_dec;
          wrap     <= (pos == '0);
        end else begin
          disp_val <= disp_shl;
          pos      <= pos_inc;
          rd_idx   <= rd_idx_inc;
          wrap     <= (pos == len_last);
        end
      end
    end
  end

endmodule

// File: tb/tb_scroll_window_ctrl.sv
// Bench for scroll_window_ctrl with DIGITS=4, DEPTH=16, TICK_DIV=4.
// Stimulus queues hand-computed windows; a monitor compares each window as busy falls.
module tb_scroll_window_ctrl;
  localparam int DIGITS   = 4;
  localparam int DEPTH    = 16;
  localparam int TICK_DIV = 4;
  localparam int AW       = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [3:0]    wr_data;
  logic [AW:0]   msg_len;
  logic          run, dir, step, reload;
  logic [15:0]   disp_val;
  logic [AW-1:0] pos;
  logic          busy, wrap;

  scroll_window_ctrl #(.DIGITS(DIGITS), .DEPTH(DEPTH), .TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .msg_len(msg_len), .run(run), .dir(dir), .step(step), .reload(reload),
    .disp_val(disp_val), .pos(pos), .busy(busy), .wrap(wrap)
  );

  typedef struct packed {
    logic [15:0] disp;
    logic [3:0]  pos;
    logic        wrap;
  } exp_t;

  exp_t exp_q[$];
  int   pres_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   seen   = 0;
  int   cyc    = 0;
  logic prev_busy = 1'b0;
  exp_t mon_e;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [15:0] d, input logic [3:0] p, input logic w);
    exp_t e;
    e.disp = d;
    e.pos  = p;
    e.wrap = w;
    exp_q.push_back(e);
  endtask

  // Monitor: a finished LOAD or FETCH (busy falling) presents a new window
  always @(negedge clk) begin
    if (reset) begin
      prev_busy = 1'b0;
    end else begin
      if (prev_busy && !busy) begin
        seen++;
        pres_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_window: got disp=%h pos=%0d, required no window", disp_val, pos);
        end else begin
          mon_e = exp_q.pop_front();
          chk("window_disp", 32'(disp_val), 32'(mon_e.disp));
          chk("window_pos", 32'(pos), 32'(mon_e.pos));
          chk("window_wrap", 32'(wrap), 32'(mon_e.wrap));
        end
      end else begin
        chk("wrap_outside_advance", 32'(wrap), 32'd0);
      end
      prev_busy = busy;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_seen(input int n);
    int k = 0;
    while (seen < n && k < 300) begin
      tick();
      k++;
    end
    if (seen < n) begin
      checks++;
      errors++;
      $display("FAIL wait_window: got %0d windows, required %0d", seen, n);
    end
  endtask

  task automatic wait_busy();
    int k = 0;
    while (!busy && k < 30) begin
      tick();
      k++;
    end
    chk("wait_fetch_busy", 32'(busy), 32'd1);
  endtask

  task automatic chk_period(input string name, input int req);
    int n = pres_cyc.size();
    if (n < 2) begin
      chk(name, 32'd0, 32'(req));
    end else begin
      chk(name, 32'(pres_cyc[n-1] - pres_cyc[n-2]), 32'(req));
    end
  endtask

  task automatic wr(input int a, input int d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = 4'(d);
    tick();
    wr_en   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, required finish before 100000 ns");
    $fatal(1);
  end

  initial begin
    int base;
    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    msg_len = 5'd6; run = 1'b0; dir = 1'b0; step = 1'b0; reload = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("reset_disp", 32'(disp_val), 32'h0);
    chk("reset_pos", 32'(pos), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_wrap", 32'(wrap), 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Basic left scroll over 1..6 through a full wrap
    for (int i = 0; i < 6; i++) wr(i, i + 1);
    msg_len = 5'd6; dir = 1'b0;
    push_exp(16'h1234, 4'd0, 1'b0);
    push_exp(16'h2345, 4'd1, 1'b0);
    push_exp(16'h3456, 4'd2, 1'b0);
    push_exp(16'h4561, 4'd3, 1'b0);
    push_exp(16'h5612, 4'd4, 1'b0);
    push_exp(16'h6123, 4'd5, 1'b0);
    push_exp(16'h1234, 4'd0, 1'b1);
    run = 1'b1;
    wait_seen(7);
    run = 1'b0;
    chk_period("scroll_period", 6);
    repeat (8) tick();
    chk("freeze_disp", 32'(disp_val), 32'h1234);
    chk("freeze_busy", 32'(busy), 32'd0);

    // Right scroll on a 3-nibble message shorter than the window
    wr(0, 10); wr(1, 11); wr(2, 12);
    msg_len = 5'd3; dir = 1'b1;
    base = seen;
    push_exp(16'hABCA, 4'd0, 1'b0);
    push_exp(16'hCABC, 4'd2, 1'b1);
    push_exp(16'hBCAB, 4'd1, 1'b0);
    run = 1'b1;
    wait_seen(base + 3);
    run = 1'b0;
    repeat (3) tick();

    // Step coinciding with the tick, then an early step
    msg_len = 5'd6; dir = 1'b0;
    base = seen;
    push_exp(16'hBC45, 4'd1, 1'b0);
    run = 1'b1;
    wait_seen(base + 1);
    push_exp(16'hC456, 4'd2, 1'b0);
    push_exp(16'h456A, 4'd3, 1'b0);
    repeat (3) tick();
    step = 1'b1;
    tick();
    step = 1'b0;
    wait_seen(base + 2);
    chk_period("step_tick_period", 6);
    wait_seen(base + 3);
    chk_period("after_step_period", 6);
    push_exp(16'h56AB, 4'd4, 1'b0);
    tick();
    step = 1'b1;
    tick();
    step = 1'b0;
    wait_seen(base + 4);
    chk_period("early_step_period", 4);
    run = 1'b0;
    repeat (3) tick();

    // Reset asserted during FETCH
    base = seen;
    push_exp(16'h56AB, 4'd4, 1'b0);
    run = 1'b1;
    wait_seen(base + 1);
    wait_busy();
    reset = 1'b1;
    #1;
    chk("rst_fetch_disp", 32'(disp_val), 32'h0);
    chk("rst_fetch_pos", 32'(pos), 32'd0);
    chk("rst_fetch_busy", 32'(busy), 32'd0);
    chk("rst_fetch_wrap", 32'(wrap), 32'd0);
    run = 1'b0;
    tick(); tick();
    reset = 1'b0;
    repeat (6) tick();
    chk("post_rst_idle_disp", 32'(disp_val), 32'h0);
    chk("post_rst_idle_busy", 32'(busy), 32'd0);

    // msg_len=0 acts as length 1; step during LOAD is ignored
    msg_len = 5'd0; dir = 1'b0;
    base = seen;
    push_exp(16'hAAAA, 4'd0, 1'b0);
    push_exp(16'hAAAA, 4'd0, 1'b1);
    run = 1'b1;
    tick();
    step = 1'b1;
    tick(); tick();
    step = 1'b0;
    wait_seen(base + 2);
    run = 1'b0;
    chk_period("len1_period", 6);

    // Writes while frozen leave the display untouched
    for (int i = 0; i < 16; i++) wr(i, i);
    tick();
    chk("write_no_disp_change", 32'(disp_val), 32'hAAAA);
    chk("write_no_pos_change", 32'(pos), 32'd0);

    // msg_len=20 clamps to 16; reload in SHOW rebuilds from pos
    msg_len = 5'd20; dir = 1'b0;
    base = seen;
    push_exp(16'h0123, 4'd0, 1'b0);
    push_exp(16'h1234, 4'd1, 1'b0);
    run = 1'b1;
    wait_seen(base + 2);
    push_exp(16'h1234, 4'd1, 1'b0);
    push_exp(16'h0123, 4'd0, 1'b0);
    push_exp(16'hF012, 4'd15, 1'b1);
    reload = 1'b1;
    dir = 1'b1;
    tick();
    reload = 1'b0;
    wait_seen(base + 3);
    chk_period("reload_period", 6);
    wait_seen(base + 5);
    run = 1'b0;

    // reload while idle and run=0 is ignored
    tick();
    reload = 1'b1;
    tick();
    reload = 1'b0;
    repeat (6) tick();
    chk("idle_reload_busy", 32'(busy), 32'd0);
    chk("idle_reload_disp", 32'(disp_val), 32'hF012);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/scroll_window_ctrl.md
# scroll_window_ctrl

Parametrised scrolling-message engine for the seven-segment display path. It holds a message of up to DEPTH hex nibbles in an internal single-port-write, registered-read buffer, and presents a DIGITS-wide window of that message. The window scrolls left or right on a programmable time base or on manual step pulses, wrapping around the message end. Its output drives the existing hex_to_sseg / disp_mux chain, replacing the fixed 8-digit shift-register scroller.

## Interface
- DIGITS, 8, number of displayed nibbles; must be 1..DEPTH
- DEPTH, 64, message buffer depth in nibbles
- TICK_DIV, 100000000, clk cycles per automatic scroll step; must be >= 2
- AW, $clog2(DEPTH), buffer address width (derived)
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- wr_en  in  1  write wr_data to buffer[wr_addr] this cycle
- wr_addr  in  AW  buffer write address
- wr_data  in  4  nibble to write
- msg_len  in  AW+1  message length; 0 is treated as 1, values above DEPTH as DEPTH
- run  in  1  level; 1 = load and scroll, 0 = freeze
- dir  in  1  0 = scroll left (pos increments), 1 = scroll right (pos decrements)
- step  in  1  single-cycle manual advance request
- reload  in  1  single-cycle request to rebuild the window from pos
- disp_val  out  4*DIGITS  window; MSB nibble = buffer[pos], next = buffer[(pos+1) mod len], and so on
- pos  out  AW  message index shown in the MSB digit
- busy  out  1  high in LOAD and FETCH
- wrap  out  1  one-cycle pulse when pos wraps

## Operation
- States: IDLE, LOAD, SHOW, FETCH. Reset → IDLE, pos=0, disp_val=0, divider=0, busy=0, wrap=0, and the latched length len=1. Buffer contents are not reset.
- IDLE: disp_val and pos hold. Transition to LOAD when run=1.
- LOAD: latch len from msg_len (after clamping). Read DIGITS nibbles starting at pos, incrementing the read index mod len. Each nibble returned shifts into disp_val from the right (disp_val <= {disp_val[4*DIGITS-5:0], nib}). After DIGITS shifts, go to SHOW and clear the divider. If len < DIGITS, the message repeats across the window.
- SHOW: the divider counts 0..TICK_DIV-1. An advance occurs when the divider reaches TICK_DIV-1 or when step=1. A tick and a step in the same cycle produce one advance. An advance resets the divider and goes to FETCH.
  - run=0 in SHOW: go to IDLE and hold the window.
  - reload=1 in SHOW or IDLE (with run=1): go to LOAD.
- FETCH, left (dir=0): read buffer[(pos+DIGITS) mod len], shift it in from the right, set pos <= (pos+1) mod len.
- FETCH, right (dir=1): read buffer[(pos-1) mod len], shift it in at the MSB (disp_val <= {nib, disp_val[4*DIGITS-1:4]}), set pos <= (pos-1) mod len.
- FETCH then returns to SHOW.
- wrap pulses on the cycle pos changes from len-1 to 0 (left) or from 0 to len-1 (right). With len=1, every advance pulses wrap and pos stays 0.
- step, reload and run=0 are ignored during LOAD and FETCH. reload is ignored in IDLE while run=0.
- Writes are accepted in every state and never stall.
  - Write and read to the same address in the same cycle: the read returns the old data.
  - Writes do not alter disp_val until that location is next fetched or reloaded.
- msg_len changes take effect only at the next LOAD. dir is sampled on the advance cycle.

## Timing
- Buffer read latency is 1 cycle.
- LOAD lasts DIGITS+1 cycles from entry to SHOW, and busy is high throughout.
- Advance at edge n: FETCH at n+1; disp_val, pos and wrap update at edge n+2; SHOW at n+2.
- Automatic scroll period in steady state is TICK_DIV+2 cycles: TICK_DIV in SHOW plus 2 in FETCH.
- Reset asserted mid-LOAD or mid-FETCH clears everything asynchronously. No partial shift survives.
- All outputs are registered.

## Test plan
Bench parameters: DIGITS=4, DEPTH=16, TICK_DIV=4.

- Basic scroll. Write buffer[0..5]=1,2,3,4,5,6; msg_len=6; run=1. After 5 LOAD cycles, disp_val=16'h1234 and pos=0. After each advance, disp_val goes 2345, then 3456, then 4561.
- Wrap pulse. Continuing from the basic scroll, reach pos=5, then advance once. Required: pos=0, disp_val=16'h1234, wrap high for exactly 1 cycle. The scroll period measures 6 cycles.
- Right scroll and short message. msg_len=3 with buffer=A,B,C; dir=1. Reload shows ABCA. One advance gives CABC with pos=2 and a wrap pulse.
- Step coincidence. Assert step on the same cycle the divider hits 3. Required: exactly one advance; the next auto advance comes 4 SHOW cycles later.
- Freeze and edge controls. run=0 in SHOW gives IDLE with the display held. msg_len=0 behaves as len=1. msg_len=20 clamps to 16. Step during LOAD has no effect.
- Reset mid-FETCH. Assert reset during FETCH. Required immediately: disp_val=0, pos=0, busy=0, state IDLE.
